// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and decoded key outputs shared by the scanner and its consumer.
// The scanner side is master; the keypad/consumer side is slave.
interface keypad_scanner_if;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  col_in,
      output row_out,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output col_in,
      input  row_out,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows in turn, samples synchronized columns,
// debounces whole scan frames and emits one key code per physical press.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 5
) (
   input logic               clock_50Mhz,
   input logic               reset,
   keypad_scanner_if.master  kp
);

   localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
   localparam int unsigned CNT_W  = 4;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  DEB_N     = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

   logic [3:0]        col_s1, col_s2;
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        row_idx;
   logic [3:0]        row_q;
   logic              slot_end, frame_end;

   logic [1:0]        press_cnt;
   logic [3:0]        first_key;
   logic              held_seen;
   logic [3:0]        col_low;
   logic [2:0]        press_sum;
   logic [1:0]        press_sat;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [3:0]        cand_q, cand_d;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q, key_held_d;
   logic              is_none, is_single;

   function automatic logic [2:0] ones4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   function automatic logic [1:0] lowest4(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Two-flop synchronizer for the asynchronous column lines
   always_ff @(posedge clock_50Mhz or posedge reset) begin
      if (reset) begin
         col_s1 <= 4'b1111;
         col_s2 <= 4'b1111;
      end else begin
         col_s1 <= kp.col_in;
         col_s2 <= col_s1;
      end
   end

   assign slot_end = (scan_cnt == SCAN_LAST);

   // Row scan: one row low per slot, frame result flagged the cycle after the row-3 sample
   always_ff @(posedge clock_50Mhz or posedge reset) begin
      if (reset) begin
         scan_cnt  <= '0;
         row_idx   <= 2'd0;
         row_q     <= 4'b1110;
         frame_end <= 1'b0;
      end else begin
         scan_cnt  <= slot_end ? '0 : scan_cnt + SCAN_W'(1);
         frame_end <= slot_end && (row_idx == 2'd3);
         if (slot_end) begin
            row_idx <= row_idx + 2'd1;
            row_q   <= {row_q[2:0], row_q[3]};
         end
      end
   end

   assign col_low   = ~col_s2;
   assign press_sum = {1'b0, press_cnt} + ones4(col_low);
   assign press_sat = (press_sum >= 3'd2) ? 2'd2 : press_sum[1:0];

   // Per-frame accumulators; slot_end and frame_end never coincide since SCAN_DIV >= 4
   always_ff @(posedge clock_50Mhz or posedge reset) begin
      if (reset) begin
         press_cnt <= 2'd0;
         first_key <= 4'd0;
         held_seen <= 1'b0;
      end else if (frame_end) begin
         press_cnt <= 2'd0;
         first_key <= 4'd0;
         held_seen <= 1'b0;
      end else if (slot_end) begin
         press_cnt <= press_sat;
         if (press_cnt == 2'd0 && col_low != 4'd0)
            first_key <= {row_idx, lowest4(col_low)};
         if (row_idx == key_code_q[3:2] && col_low[key_code_q[1:0]])
            held_seen <= 1'b1;
      end
   end

   assign is_none   = (press_cnt == 2'd0);
   assign is_single = (press_cnt == 2'd1);
   assign cnt_inc   = cnt_q + CNT_W'(1);

   always_ff @(posedge clock_50Mhz or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cand_q      <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // Debounce FSM, advanced once per completed frame
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      if (frame_end) begin
         unique case (state_q)
            IDLE: begin
               if (is_single) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d     = PRESSED;
                     cnt_d       = '0;
                     key_code_d  = first_key;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                  end else begin
                     state_d = DEBOUNCE;
                     cand_d  = first_key;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            DEBOUNCE: begin
               if (is_single && first_key == cand_q) begin
                  if (cnt_inc >= DEB_N) begin
                     state_d     = PRESSED;
                     cnt_d       = '0;
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            PRESSED: begin
               if (!held_seen) begin
                  if (DEBOUNCE_SCANS == 1 && is_none) begin
                     state_d    = IDLE;
                     cnt_d      = '0;
                     key_held_d = 1'b0;
                  end else begin
                     state_d = RELEASE;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (held_seen) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (is_none) begin
                  if (cnt_inc >= DEB_N) begin
                     state_d    = IDLE;
                     cnt_d      = '0;
                     key_held_d = 1'b0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign kp.row_out   = row_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle frames)
// and a behavioural key matrix pulling columns low for the driven row.
module tb_keypad_scanner;

   logic clock_50Mhz = 1'b0;
   logic reset;
   logic [15:0] keys;

   keypad_scanner_if kp ();

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clock_50Mhz (clock_50Mhz),
      .reset       (reset),
      .kp          (kp)
   );

   always #10 clock_50Mhz = ~clock_50Mhz;

   // Key (r,c) is bit r*4+c; a pressed key shorts its row to its column
   always_comb begin
      kp.col_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.row_out[r] && keys[r*4+c]) kp.col_in[c] = 1'b0;
   end

   int cyc;
   int pulses = 0;
   int last_pulse = -1;
   int onehot_err = 0;
   int checks = 0;
   int failures = 0;

   always @(posedge clock_50Mhz or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   always @(negedge clock_50Mhz) begin
      if (!reset) begin
         if (kp.key_valid) begin
            pulses++;
            last_pulse = cyc;
         end
         if ($countones(~kp.row_out) != 1) onehot_err++;
      end
   end

   typedef struct {
      int         cyc;
      logic [3:0] exp_row;
   } row_vec_t;

   row_vec_t rv [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clock_50Mhz);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_row_out"},   32'(kp.row_out),   32'h0000_000E);
      check({tag, "_key_code"},  32'(kp.key_code),  32'h0);
      check({tag, "_key_valid"}, 32'(kp.key_valid), 32'h0);
      check({tag, "_key_held"},  32'(kp.key_held),  32'h0);
   endtask

   initial begin
      int p;
      rv[0]  = '{0,  4'b1110};  rv[1]  = '{3,  4'b1110};
      rv[2]  = '{4,  4'b1101};  rv[3]  = '{7,  4'b1101};
      rv[4]  = '{8,  4'b1011};  rv[5]  = '{11, 4'b1011};
      rv[6]  = '{12, 4'b0111};  rv[7]  = '{15, 4'b0111};
      rv[8]  = '{16, 4'b1110};  rv[9]  = '{20, 4'b1101};
      rv[10] = '{24, 4'b1011};  rv[11] = '{28, 4'b0111};

      keys  = 16'h0;
      reset = 1'b1;
      repeat (3) @(negedge clock_50Mhz);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;

      // Free-running row scan
      for (int i = 0; i < 12; i++) begin
         wait_cyc(rv[i].cyc);
         check($sformatf("row_out@%0d", rv[i].cyc), 32'(kp.row_out), 32'(rv[i].exp_row));
      end
      check("freerun_no_pulse", 32'(pulses), 32'd0);

      // Clean press of (r1,c2) from a frame boundary
      wait_cyc(32);
      keys[6] = 1'b1;
      p = pulses;
      wait_cyc(80);
      check("press_held_before", 32'(kp.key_held), 32'd0);
      wait_cyc(81);
      check("press_valid", 32'(kp.key_valid), 32'd1);
      check("press_code", 32'(kp.key_code), 32'h6);
      wait_cyc(82);
      check("press_valid_one_cycle", 32'(kp.key_valid), 32'd0);
      check("press_held", 32'(kp.key_held), 32'd1);
      wait_cyc(128);
      check("press_pulse_count", 32'(pulses - p), 32'd1);
      check("press_pulse_cycle", 32'(last_pulse), 32'd81);

      // Release after 3 empty frames, then re-press
      keys = 16'h0;
      wait_cyc(176);
      check("release_held_still", 32'(kp.key_held), 32'd1);
      wait_cyc(177);
      check("release_held_drop", 32'(kp.key_held), 32'd0);
      check("release_code_kept", 32'(kp.key_code), 32'h6);
      wait_cyc(192);
      keys[6] = 1'b1;
      p = pulses;
      wait_cyc(256);
      check("repress_pulse_count", 32'(pulses - p), 32'd1);
      check("repress_pulse_cycle", 32'(last_pulse), 32'd241);
      check("repress_code", 32'(kp.key_code), 32'h6);
      keys = 16'h0;
      wait_cyc(305);
      check("repress_release", 32'(kp.key_held), 32'd0);

      // Ghost: two keys in row 0 from IDLE
      wait_cyc(320);
      keys = 16'h0003;
      p = pulses;
      wait_cyc(384);
      check("ghost_no_pulse", 32'(pulses - p), 32'd0);
      check("ghost_code_kept", 32'(kp.key_code), 32'h6);
      check("ghost_not_held", 32'(kp.key_held), 32'd0);
      keys = 16'h0;
      wait_cyc(416);
      keys[0] = 1'b1;
      p = pulses;
      wait_cyc(480);
      check("r0c0_pulse_count", 32'(pulses - p), 32'd1);
      check("r0c0_pulse_cycle", 32'(last_pulse), 32'd465);
      check("r0c0_code", 32'(kp.key_code), 32'h0);
      keys[15] = 1'b1;
      p = pulses;
      wait_cyc(544);
      check("held_plus_r3c3_no_pulse", 32'(pulses - p), 32'd0);
      check("held_plus_r3c3_held", 32'(kp.key_held), 32'd1);
      check("held_plus_r3c3_code", 32'(kp.key_code), 32'h0);
      keys = 16'h0;
      wait_cyc(593);
      check("ghost_release", 32'(kp.key_held), 32'd0);

      // Bounce: toggle (r1,c2) every 20 cycles, then hold stable
      wait_cyc(608);
      p = pulses;
      for (int i = 0; i < 4; i++) begin
         wait_cyc(608 + 20 * i);
         keys[6] = (i % 2 == 0);
      end
      wait_cyc(688);
      check("bounce_no_pulse", 32'(pulses - p), 32'd0);
      keys[6] = 1'b1;
      p = pulses;
      wait_cyc(768);
      check("bounce_stable_count", 32'(pulses - p), 32'd1);
      check("bounce_stable_cycle", 32'(last_pulse), 32'd737);
      check("bounce_stable_code", 32'(kp.key_code), 32'h6);
      keys = 16'h0;
      wait_cyc(817);
      check("bounce_release", 32'(kp.key_held), 32'd0);

      // Reset after two matching frames of (r2,c3)
      wait_cyc(832);
      keys[11] = 1'b1;
      wait_cyc(870);
      check("prereset_code", 32'(kp.key_code), 32'h6);
      check("prereset_row", 32'(kp.row_out), 32'(4'b1101));
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(negedge clock_50Mhz);
      #1;
      reset = 1'b0;
      p = pulses;
      wait_cyc(48);
      check("postreset_no_early_pulse", 32'(pulses - p), 32'd0);
      check("postreset_not_held", 32'(kp.key_held), 32'd0);
      wait_cyc(49);
      check("postreset_valid", 32'(kp.key_valid), 32'd1);
      check("postreset_code", 32'(kp.key_code), 32'hB);
      wait_cyc(64);
      check("postreset_pulse_count", 32'(pulses - p), 32'd1);
      check("postreset_held", 32'(kp.key_held), 32'd1);
      keys = 16'h0;

      check("row_onehot_every_cycle", 32'(onehot_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
